sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (legal 2..4).
REQ-002 Parameter DATA_BUS_WIDTH, default 64, SRAM data width.
REQ-003 Parameter ADDR_BUS_WIDTH, default 64, SRAM address width.
REQ-004 Parameter MAX_BURST, default 8, maximum consecutive locked grants (legal 1..255).
REQ-005 Port clk input 1 -- single clock; all state on posedge clk.
REQ-006 Port rst input 1 -- synchronous active-high reset.
REQ-007 Port req input NUM_REQ -- per-requester access request.
REQ-008 Port req_lock input NUM_REQ -- requester asks to keep the grant next cycle.
REQ-009 Port req_gwen input NUM_REQ -- per-requester write enable, 0 = write, 1 = read.
REQ-010 Port req_addr input NUM_REQ x ADDR_BUS_WIDTH -- per-requester address.
REQ-011 Port req_wdata input NUM_REQ x DATA_BUS_WIDTH -- per-requester write data.
REQ-012 Port gnt output NUM_REQ -- one-hot grant, same cycle as the accepted request.
REQ-013 Port rvalid output NUM_REQ -- one-hot read-data-valid pulse.
REQ-014 Port rdata output DATA_BUS_WIDTH -- read data, shared by all requesters; qualified by rvalid.
REQ-015 Port mem_sram_CEN output 1 -- SRAM chip enable, active low.
REQ-016 Port mem_sram_A output ADDR_BUS_WIDTH -- SRAM address.
REQ-017 Port mem_sram_D output DATA_BUS_WIDTH -- SRAM write data.
REQ-018 Port mem_sram_GWEN output 1 -- SRAM write enable, 0 = write.
REQ-019 Port mem_sram_Q input DATA_BUS_WIDTH -- SRAM read data, valid one cycle after the read-enable edge.

Function
REQ-020 gnt shall be combinational from req and arbiter state, with at most one bit set.
REQ-021 When gnt[i]=1, mem_sram_CEN shall be 0 and A, D and GWEN shall equal requester i's req_addr, req_wdata and req_gwen in the same cycle.
REQ-022 With no grant, mem_sram_CEN shall be 1, GWEN 1, and A and D 0.
REQ-023 The FSM shall have states RR and LOCKED.
REQ-024 In RR, the grant shall go to the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-025 On any grant in RR, rr_ptr shall update to (granted index + 1) mod NUM_REQ.
REQ-026 The transition RR->LOCKED shall occur when granted requester i has req_lock[i]=1; the FSM shall record owner=i and set burst_cnt=1.
REQ-027 In LOCKED, only the owner shall be granted; other requests shall wait with gnt 0.
REQ-028 Each owner grant in LOCKED shall increment burst_cnt.
REQ-029 The transition LOCKED->RR shall occur after a granted cycle with req_lock[owner]=0, or when burst_cnt reaches MAX_BURST, or when req[owner]=0 (no grant that cycle).
REQ-030 On the LOCKED->RR transition, rr_ptr shall be set to owner+1 mod NUM_REQ.
REQ-031 rvalid[i] shall pulse exactly one cycle after a granted read (gwen=1) by requester i, with rdata=mem_sram_Q in that cycle.
REQ-032 Writes shall produce no rvalid.
REQ-033 Back-to-back reads shall return in issue order with one-cycle latency and no bubbles.
REQ-034 rdata shall be 0 whenever rvalid is all-zero.

Reset
REQ-035 While rst=1: state RR, rr_ptr=0, owner=0, burst_cnt=0, rvalid=0, gnt=0, mem_sram_CEN=1, mem_sram_GWEN=1.
REQ-036 Reset asserted mid-burst shall abort the lock.
REQ-037 Reset shall suppress any rvalid pending from the cycle before reset.
REQ-038 The first grant shall be possible in the first cycle after rst deasserts.

Configuration
REQ-039 Macro SRAM_ARB_LOCK_EN: when defined, the LOCKED state and burst_cnt shall exist as specified.
REQ-040 When SRAM_ARB_LOCK_EN is not defined, req_lock shall be ignored, the FSM shall remain in RR permanently, and the port list shall be unchanged.

Verification
REQ-041 After reset, req=2'b11, both reads to addr 1 and 2 -> cycle 0 gnt=01 A=1; cycle 1 gnt=10 A=2 and rvalid=01; cycle 2 rvalid=10.
REQ-042 Requester 0 holds req and req_lock for 3 reads (A=1,2,3) while requester 1 requests -> gnt=01 for 3 cycles, then gnt=10; rvalid[0] 3 consecutive pulses.
REQ-043 MAX_BURST=2 and requester 0 keeps locking while requester 1 waits -> requester 1 is granted on the 3rd cycle.
REQ-044 Requester 1 writes 64'h3C00_4000_4200_3E00 to A=5, then requester 0 reads A=5 -> CEN=0 GWEN=0 on the write, no rvalid; rdata=64'h3C00_4000_4200_3E00 with rvalid=01.
REQ-045 rst asserted in the cycle after a granted read during LOCKED -> rvalid stays 0, state RR, next grant follows rr_ptr=0.
REQ-046 Build without SRAM_ARB_LOCK_EN, repeat REQ-042 -> grants alternate 01,10,01 despite req_lock.

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Arbitrates NUM_REQ requesters onto one single-port synchronous SRAM.
// Grants are combinational from the current requests and the arbiter state,
// so a granted request reaches the SRAM pins in the same cycle.  Read data
// comes back one cycle later on the shared rdata bus and is tagged by a
// one-hot rvalid pulse that names the requester that issued the read.
//
// Arbitration: round robin starting at rr_ptr.  With the SRAM_ARB_LOCK_EN
// macro defined, a granted requester that raises req_lock keeps the grant
// for up to MAX_BURST consecutive cycles (LOCKED state).  Without the macro,
// req_lock is ignored and the arbiter stays in plain round robin; the port
// list is identical in both builds.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   rst            in   synchronous active-high reset
//   req            in   [NUM_REQ]     access request per requester
//   req_lock       in   [NUM_REQ]     keep the grant next cycle
//   req_gwen       in   [NUM_REQ]     0 = write, 1 = read
//   req_addr       in   [NUM_REQ][ADDR_BUS_WIDTH] address per requester
//   req_wdata      in   [NUM_REQ][DATA_BUS_WIDTH] write data per requester
//   gnt            out  [NUM_REQ]     one-hot grant (same cycle)
//   rvalid         out  [NUM_REQ]     one-hot read-data-valid pulse
//   rdata          out  [DATA_BUS_WIDTH] shared read data, 0 when no rvalid
//   mem_sram_CEN   out  SRAM chip enable, active low
//   mem_sram_A     out  SRAM address
//   mem_sram_D     out  SRAM write data
//   mem_sram_GWEN  out  SRAM write enable, 0 = write
//   mem_sram_Q     in   SRAM read data, one cycle after the read edge
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int ADDR_BUS_WIDTH = 64,
  parameter int MAX_BURST      = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req,
  input  logic [NUM_REQ-1:0]                      req_lock,
  input  logic [NUM_REQ-1:0]                      req_gwen,
  input  logic [NUM_REQ-1:0][ADDR_BUS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_BUS_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                      gnt,
  output logic [NUM_REQ-1:0]                      rvalid,
  output logic [DATA_BUS_WIDTH-1:0]               rdata,
  output logic                                    mem_sram_CEN,
  output logic [ADDR_BUS_WIDTH-1:0]               mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0]               mem_sram_D,
  output logic                                    mem_sram_GWEN,
  input  logic [DATA_BUS_WIDTH-1:0]               mem_sram_Q
);

  localparam int               IDX_W       = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

`ifdef SRAM_ARB_LOCK_EN
  // With MAX_BURST = 1 the very first grant already exhausts the burst,
  // so the lock is never entered.
  localparam bit         LOCK_ALLOWED = (MAX_BURST > 1);
  localparam logic [7:0] MAX_BURST_C  = 8'(MAX_BURST);

  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [7:0]       burst_cnt_reg, burst_cnt_next;
  logic [7:0]       burst_inc;
`else
  // req_lock has no effect in this build; fold it into a sink signal.
  logic lock_unused;
  assign lock_unused = ^req_lock;
`endif

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant_en;
  logic             read_issue;
  logic [NUM_REQ-1:0] rvalid_reg;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Round-robin search: candidate gi is (rr_ptr + gi) mod NUM_REQ, so the
  // lowest-numbered requesting candidate is the winner.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (sum >= NUM_REQ_EXT) ? IDX_W'(sum - NUM_REQ_EXT)
                                                 : sum[IDX_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    // Walk from the far end so the nearest candidate is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RR;
      rr_ptr_reg    <= '0;
`ifdef SRAM_ARB_LOCK_EN
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
`ifdef SRAM_ARB_LOCK_EN
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    gnt_any        = 1'b0;
    gnt_idx        = rr_idx;
`ifdef SRAM_ARB_LOCK_EN
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    burst_inc      = burst_cnt_reg + 8'd1;
`endif

    case (state_reg)
      ST_RR: begin
        if (rr_found) begin
          gnt_any     = 1'b1;
          gnt_idx     = rr_idx;
          rr_ptr_next = wrap_inc(rr_idx);
`ifdef SRAM_ARB_LOCK_EN
          if (LOCK_ALLOWED && req_lock[rr_idx]) begin
            state_next     = ST_LOCKED;
            owner_next     = rr_idx;
            burst_cnt_next = 8'd1;
          end
`endif
        end
      end

`ifdef SRAM_ARB_LOCK_EN
      ST_LOCKED: begin
        if (req[owner_reg]) begin
          gnt_any        = 1'b1;
          gnt_idx        = owner_reg;
          burst_cnt_next = burst_inc;
          if (!req_lock[owner_reg] || (burst_inc >= MAX_BURST_C)) begin
            state_next     = ST_RR;
            rr_ptr_next    = wrap_inc(owner_reg);
            burst_cnt_next = '0;
          end
        end else begin
          // Owner dropped its request: give up the lock without a grant.
          state_next     = ST_RR;
          rr_ptr_next    = wrap_inc(owner_reg);
          burst_cnt_next = '0;
        end
      end
`endif

      default: begin
        state_next = ST_RR;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant decode and SRAM pin mux.  Reset blocks grants combinationally so
  // the SRAM sees an idle bus for every cycle rst is high.
  // -------------------------------------------------------------------------
  assign grant_en = gnt_any & ~rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = grant_en && (gnt_idx == IDX_W'(gi));
    end
  endgenerate

  assign mem_sram_CEN  = ~grant_en;
  assign mem_sram_GWEN = grant_en ? req_gwen[gnt_idx]  : 1'b1;
  assign mem_sram_A    = grant_en ? req_addr[gnt_idx]  : '0;
  assign mem_sram_D    = grant_en ? req_wdata[gnt_idx] : '0;

  // -------------------------------------------------------------------------
  // Read return: the SRAM answers one cycle after the read edge, so a
  // one-cycle delayed copy of the grant tags the returning data.  Issue
  // order is preserved for free since there is a single slot.
  // -------------------------------------------------------------------------
  assign read_issue = grant_en & req_gwen[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg <= '0;
    end else begin
      rvalid_reg <= read_issue ? gnt : '0;
    end
  end

  // A read granted in the cycle before reset would otherwise surface while
  // rst is high; mask it so reset always wins.
  assign rvalid = rst ? '0 : rvalid_reg;
  assign rdata  = (|rvalid) ? mem_sram_Q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Two arbiters (MAX_BURST 8 and 2) share the same directed stimulus, each
// with its own behavioural SRAM.  A reference model derived from the
// arbitration rules predicts every output on every cycle; a few literal
// expectations pin the model on the documented scenarios.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]         req      = '0;
  logic [N-1:0]         req_lock = '0;
  logic [N-1:0]         req_gwen = '1;
  logic [N-1:0][AW-1:0] req_addr  = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;

  logic [N-1:0]  gnt_w      [2];
  logic [N-1:0]  rvalid_w   [2];
  logic [DW-1:0] rdata_w    [2];
  logic          mem_cen_w  [2];
  logic [AW-1:0] mem_a_w    [2];
  logic [DW-1:0] mem_d_w    [2];
  logic          mem_gwen_w [2];
  logic [DW-1:0] mem_q_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(N), .DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .MAX_BURST(8)) u_dut_b8 (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_gwen(req_gwen),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_w[0]), .rvalid(rvalid_w[0]),
    .rdata(rdata_w[0]), .mem_sram_CEN(mem_cen_w[0]), .mem_sram_A(mem_a_w[0]),
    .mem_sram_D(mem_d_w[0]), .mem_sram_GWEN(mem_gwen_w[0]), .mem_sram_Q(mem_q_w[0])
  );

  sram_arbiter #(.NUM_REQ(N), .DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .MAX_BURST(2)) u_dut_b2 (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_gwen(req_gwen),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_w[1]), .rvalid(rvalid_w[1]),
    .rdata(rdata_w[1]), .mem_sram_CEN(mem_cen_w[1]), .mem_sram_A(mem_a_w[1]),
    .mem_sram_D(mem_d_w[1]), .mem_sram_GWEN(mem_gwen_w[1]), .mem_sram_Q(mem_q_w[1])
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural SRAMs: sample the request mid-cycle, act on the next edge.
  // -------------------------------------------------------------------------
  logic [DW-1:0] sram [2][16];

  initial begin
    logic          s_cen  [2];
    logic          s_gwen [2];
    logic [3:0]    s_a    [2];
    logic [DW-1:0] s_d    [2];
    for (int i = 0; i < 2; i++) begin
      mem_q_w[i] = '0;
      for (int a = 0; a < 16; a++) sram[i][a] = init_val(a);
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s_cen[i]  = mem_cen_w[i];
        s_gwen[i] = mem_gwen_w[i];
        s_a[i]    = mem_a_w[i][3:0];
        s_d[i]    = mem_d_w[i];
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!s_cen[i]) begin
          if (!s_gwen[i]) sram[i][s_a[i]] = s_d[i];
          else            mem_q_w[i] = sram[i][s_a[i]];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model, one context per DUT instance.
  // -------------------------------------------------------------------------
  int            m_maxb      [2] = '{8, 2};
  bit            m_locked    [2] = '{0, 0};
  int            m_owner     [2] = '{0, 0};
  int            m_cnt       [2] = '{0, 0};
  int            m_ptr       [2] = '{0, 0};
  bit            m_pend      [2] = '{0, 0};
  int            m_pend_who  [2] = '{0, 0};
  logic [DW-1:0] m_pend_data [2];
  logic [DW-1:0] ref_mem     [2][16];

  // Index granted this cycle, or -1 for none.
  function automatic int pick(input int inst);
    if (rst) return -1;
    if (m_locked[inst]) return req[m_owner[inst]] ? m_owner[inst] : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr[inst] + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic advance(input int inst, input int g);
    if (rst) begin
      m_locked[inst] = 0;
      m_owner[inst]  = 0;
      m_cnt[inst]    = 0;
      m_ptr[inst]    = 0;
      m_pend[inst]   = 0;
      return;
    end
    m_pend[inst] = (g >= 0) && req_gwen[g];
    if (g >= 0) begin
      m_pend_who[inst]  = g;
      m_pend_data[inst] = ref_mem[inst][req_addr[g][3:0]];
      if (!req_gwen[g]) ref_mem[inst][req_addr[g][3:0]] = req_wdata[g];
    end
    if (m_locked[inst]) begin
      if (g < 0) begin
        m_locked[inst] = 0;
        m_ptr[inst]    = (m_owner[inst] + 1) % N;
      end else begin
        m_cnt[inst]++;
        if (!req_lock[g] || m_cnt[inst] >= m_maxb[inst]) begin
          m_locked[inst] = 0;
          m_ptr[inst]    = (m_owner[inst] + 1) % N;
        end
      end
    end else if (g >= 0) begin
      m_ptr[inst] = (g + 1) % N;
`ifdef SRAM_ARB_LOCK_EN
      if (req_lock[g] && m_maxb[inst] > 1) begin
        m_locked[inst] = 1;
        m_owner[inst]  = g;
        m_cnt[inst]    = 1;
      end
`endif
    end
  endtask

  // Compare process: every cycle, mid-cycle, both instances.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++) ref_mem[i][a] = init_val(a);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int            g;
        logic [N-1:0]  e_gnt, e_rv;
        logic [DW-1:0] e_rd;
        g     = pick(i);
        e_gnt = (g >= 0) ? N'(1 << g) : '0;
        e_rv  = (m_pend[i] && !rst) ? N'(1 << m_pend_who[i]) : '0;
        e_rd  = (m_pend[i] && !rst) ? m_pend_data[i] : '0;
        chk($sformatf("gnt[u%0d]", i),    64'(gnt_w[i]), 64'(e_gnt));
        chk($sformatf("cen[u%0d]", i),    64'(mem_cen_w[i]), 64'(g < 0));
        chk($sformatf("gwen[u%0d]", i),   64'(mem_gwen_w[i]), (g >= 0) ? 64'(req_gwen[g]) : 64'd1);
        chk($sformatf("addr[u%0d]", i),   mem_a_w[i], (g >= 0) ? req_addr[g] : 64'd0);
        chk($sformatf("wdata[u%0d]", i),  mem_d_w[i], (g >= 0) ? req_wdata[g] : 64'd0);
        chk($sformatf("rvalid[u%0d]", i), 64'(rvalid_w[i]), 64'(e_rv));
        chk($sformatf("rdata[u%0d]", i),  rdata_w[i], e_rd);
        advance(i, g);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step(input logic rs, input logic [1:0] r, input logic [1:0] lk,
                      input logic [1:0] gw, input logic [63:0] a0, input logic [63:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1);
    @(posedge clk);
    #1;
    rst          = rs;
    req          = r;
    req_lock     = lk;
    req_gwen     = gw;
    req_addr[0]  = a0;
    req_addr[1]  = a1;
    req_wdata[0] = d0;
    req_wdata[1] = d1;
    @(negedge clk);
    $display("t=%0t rst=%b req=%b lock=%b gwen=%b | gnt=%b/%b rvalid=%b/%b A=%0h/%0h",
             $time, rst, req, req_lock, req_gwen, gnt_w[0], gnt_w[1],
             rvalid_w[0], rvalid_w[1], mem_a_w[0], mem_a_w[1]);
  endtask

  localparam logic [63:0] WDAT = 64'h3C00_4000_4200_3E00;

  initial begin
    // Reset held with requests present: nothing may be granted.
    step(1, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0);
    step(1, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0);
    chk("rst_gnt", 64'(gnt_w[0]), 64'd0);
    chk("rst_cen", 64'(mem_cen_w[0]), 64'd1);
    chk("rst_gwen", 64'(mem_gwen_w[0]), 64'd1);
    chk("rst_rvalid", 64'(rvalid_w[0]), 64'd0);

    // Two reads, one per requester, right after reset.
    step(0, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0);
    chk("r041_c0_gnt", 64'(gnt_w[0]), 64'h1);
    chk("r041_c0_A", mem_a_w[0], 64'd1);
    step(0, 2'b10, 2'b00, 2'b11, 1, 2, 0, 0);
    chk("r041_c1_gnt", 64'(gnt_w[0]), 64'h2);
    chk("r041_c1_A", mem_a_w[0], 64'd2);
    chk("r041_c1_rvalid", 64'(rvalid_w[0]), 64'h1);
    chk("r041_c1_rdata", rdata_w[0], 64'hA5A5_0000_0000_0001);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
    chk("r041_c2_rvalid", 64'(rvalid_w[0]), 64'h2);
    chk("r041_c2_rdata", rdata_w[0], 64'hA5A5_0000_0000_0002);

    // Requester 0 locks for three reads while requester 1 waits.
    step(0, 2'b11, 2'b01, 2'b11, 1, 7, 0, 0);
    chk("r042_d0_gnt", 64'(gnt_w[0]), 64'h1);
    step(0, 2'b11, 2'b01, 2'b11, 2, 7, 0, 0);
`ifdef SRAM_ARB_LOCK_EN
    chk("r042_d1_gnt", 64'(gnt_w[0]), 64'h1);
`else
    chk("r046_d1_gnt", 64'(gnt_w[0]), 64'h2);
`endif
    step(0, 2'b11, 2'b00, 2'b11, 3, 7, 0, 0);
`ifdef SRAM_ARB_LOCK_EN
    chk("r042_d2_gnt", 64'(gnt_w[0]), 64'h1);
    chk("r042_d2_rvalid", 64'(rvalid_w[0]), 64'h1);
    chk("r043_b2_gnt", 64'(gnt_w[1]), 64'h2);
`else
    chk("r046_d2_gnt", 64'(gnt_w[0]), 64'h1);
`endif
    step(0, 2'b10, 2'b00, 2'b11, 0, 7, 0, 0);
    chk("r042_d3_gnt", 64'(gnt_w[0]), 64'h2);
    chk("r042_d3_rvalid", 64'(rvalid_w[0]), 64'h1);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
    chk("r042_d4_rvalid", 64'(rvalid_w[0]), 64'h2);

    // Write by requester 1, read back by requester 0.
    step(0, 2'b10, 2'b00, 2'b01, 0, 5, 0, WDAT);
    chk("r044_w_gnt", 64'(gnt_w[0]), 64'h2);
    chk("r044_w_cen", 64'(mem_cen_w[0]), 64'd0);
    chk("r044_w_gwen", 64'(mem_gwen_w[0]), 64'd0);
    chk("r044_w_D", mem_d_w[0], WDAT);
    step(0, 2'b01, 2'b00, 2'b01, 5, 0, 0, 0);
    chk("r044_r_gnt", 64'(gnt_w[0]), 64'h1);
    chk("r044_norv", 64'(rvalid_w[0]), 64'd0);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
    chk("r044_rvalid", 64'(rvalid_w[0]), 64'h1);
    chk("r044_rdata", rdata_w[0], WDAT);

    // Reset right after a locked read.
    step(0, 2'b01, 2'b01, 2'b11, 9, 0, 0, 0);
    step(0, 2'b01, 2'b01, 2'b11, 10, 0, 0, 0);
    step(1, 2'b11, 2'b01, 2'b11, 11, 12, 0, 0);
    chk("r045_rvalid", 64'(rvalid_w[0]), 64'd0);
    chk("r045_rdata", rdata_w[0], 64'd0);
    chk("r045_cen", 64'(mem_cen_w[0]), 64'd1);
    step(0, 2'b11, 2'b00, 2'b11, 11, 12, 0, 0);
    chk("r045_next_gnt", 64'(gnt_w[0]), 64'h1);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
    chk("r045_next_rv", 64'(rvalid_w[0]), 64'h1);

    // Owner drops its request while locked.
    step(0, 2'b01, 2'b01, 2'b11, 4, 6, 0, 0);
    step(0, 2'b10, 2'b00, 2'b11, 4, 6, 0, 0);
`ifdef SRAM_ARB_LOCK_EN
    chk("drop_gnt", 64'(gnt_w[0]), 64'd0);
`else
    chk("drop_gnt", 64'(gnt_w[0]), 64'h2);
`endif
    step(0, 2'b10, 2'b00, 2'b11, 4, 6, 0, 0);
    chk("drop_next_gnt", 64'(gnt_w[0]), 64'h2);

    // Random traffic checked by the model only.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           64'($urandom_range(0, 15)), 64'($urandom_range(0, 15)),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
